// File: rtl/seq_div_16x8_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Defaults describe the 16/8 configuration used with the 8x8 multipliers.
package seq_div_16x8_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_DW = 8;
    localparam int DIV_ITERS = 2 * DIV_DW;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS) + 1;
    localparam logic [DIV_ITERS-1:0] DIV_QONES = '1;
endpackage

// File: rtl/seq_div_16x8_step.sv
// One restoring-division step: shift in a dividend bit, conditionally subtract.
// Purely combinational so it can be replicated for an unrolled divider.
module div_restore_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem,
    input  logic          bin,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_next,
    output logic          qbit
);
    logic [DW:0] shifted;
    logic [DW:0] dvs_ext;
    logic        rem_msb_unused;

    // The incoming remainder is always below the divisor, so its MSB is zero
    // and the DW+1 bit shifted value cannot lose information.
    assign rem_msb_unused = rem[DW];
    assign shifted        = {rem[DW-1:0], bin};
    assign dvs_ext        = {1'b0, divisor};
    assign qbit           = (shifted >= dvs_ext);
    assign rem_next       = qbit ? (shifted - dvs_ext) : shifted;
endmodule

// File: rtl/seq_div_16x8.sv
// Iterative unsigned 2*DW / DW divider, one quotient bit per clock, valid/ready
// on both sides. Divisor 0 returns all-ones quotient and the dividend low byte.
module seq_div_16x8
    import seq_div_16x8_pkg::*;
#(
    parameter int DW = DIV_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
);
    localparam int ITERS = 2 * DW;
    localparam int CNT_W = $clog2(ITERS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS);

    div_state_t      state, state_nxt;
    logic [2*DW-1:0] work;
    logic [DW-1:0]   dvs;
    logic [DW:0]     prem;
    logic [CNT_W-1:0] cnt;
    logic [DW:0]     rem_next;
    logic            qbit;

    div_restore_step #(.DW(DW)) u_step (
        .rem      (prem),
        .bin      (work[2*DW-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // count reaches ITERS for one commit cycle after the last iteration,
    // which moves the finished quotient/remainder to the output registers.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work        <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work <= dividend;
                        dvs  <= divisor;
                        prem <= '0;
                        cnt  <= '0;
                        if (divisor == '0) begin
                            quotient    <= {(2*DW){1'b1}};
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt != LAST) begin
                        work <= {work[2*DW-2:0], qbit};
                        prem <= rem_next;
                        cnt  <= cnt + 1'b1;
                    end else begin
                        quotient    <= work;
                        remainder   <= prem[DW-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div_16x8.sv
// Directed and randomized checks of seq_div_16x8 against hand-computed values
// and a quotient/remainder reference model.
module tb_seq_div_16x8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail = 0;

    seq_div_16x8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 40);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez,
                          input int elat);
        int cyc;
        start(dd, dv);
        wait_out(cyc);
        if (elat > 0) chk({tag, "_latency"}, 32'(cyc), 32'(elat));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(remainder), 32'(er));
        chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(ez));
        handshake();
    endtask

    initial begin
        int cyc;
        int seen;
        logic [15:0] dd;
        logic [7:0]  dv;

        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        run_op("d65025_255", 16'd65025, 8'd255, 16'd255, 8'd0, 1'b0, 17);
        run_op("d65535_1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
        run_op("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17);
        run_op("d0_13", 16'd0, 8'd13, 16'd0, 8'd0, 1'b0, 17);
        run_op("dz_1234", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1);
        run_op("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0, 17);

        // Backpressure: result held while a second request waits.
        start(16'd300, 8'd20);
        wait_out(cyc);
        chk("bp_latency", 32'(cyc), 32'd17);
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd50000;
        divisor  = 8'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_quotient_stable", 32'(quotient), 32'd15);
            chk("bp_remainder_stable", 32'(remainder), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_released_out_valid", 32'(out_valid), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_out(cyc);
        chk("bp2_latency", 32'(cyc), 32'd17);
        chk("bp2_quotient", 32'(quotient), 32'd7142);
        chk("bp2_remainder", 32'(remainder), 32'd6);
        handshake();

        // Reset in the middle of an operation.
        start(16'd40000, 8'd3);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_stale_result", 32'(seen), 32'd0);
        run_op("post_rst_40000_3", 16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, 17);

        // Randomized operands against a reference model, with forced corners.
        for (int k = 0; k < 200; k++) begin
            dd = 16'($urandom);
            dv = 8'($urandom);
            if (k % 10 == 3) dv = 8'd0;
            if (k % 15 == 7) dd = 16'd0;
            if (dv == 8'd0)
                run_op("rand_dz", dd, dv, 16'hFFFF, dd[7:0], 1'b1, 1);
            else
                run_op("rand", dd, dv, dd / 16'(dv), 8'(dd % 16'(dv)), 1'b0, 17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
